hazard_ctrl: RTL and testbench

//  - Pipeline sequencer for the 5-stage core: issues stall/flush/enable controls to PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  - Resolves three hazards:
//    - load-use: detected from the ID instruction's opcode/rs fields against the EX load.
//    - taken-branch redirect: from EX.
//    - data-memory wait: via a req/ready handshake.
//  - Sits beside the decode stage and gates the register file read and immediate-generation path.

---
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer; perf counters enabled by `define HAZARD_PERF_EN
module hazard_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_id_instr,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_memread,
  input  logic             i_ex_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_memwb_bubble,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_memwait_cnt
);
  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;
  state_t state, nxt;
  logic [3:0] fcnt, fnxt;
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  logic use_rs1, use_rs2, lu, frz, take, stl, en, unused;
  assign op = i_id_instr[6:0];
  assign rs1 = i_id_instr[19:15];
  assign rs2 = i_id_instr[24:20];
  assign unused = ^{i_id_instr[31:25], i_id_instr[14:7]};
  assign use_rs1 = op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                              7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
  assign use_rs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign lu = i_ex_memread & (i_ex_rd != 5'd0) &
              ((use_rs1 & (rs1 == i_ex_rd)) | (use_rs2 & (rs2 == i_ex_rd)));
  assign frz = (state == MEMWAIT) ? !i_mem_ready : i_mem_req & !i_mem_ready;
  assign take = (state != FLUSH) & !frz & i_ex_br_taken;
  assign stl = (state != FLUSH) & !frz & !i_ex_br_taken & lu;
  assign en = !i_reset & !frz;
  assign o_pc_en = en & !stl;
  assign o_ifid_en = en & !stl;
  assign o_idex_en = en;
  assign o_exmem_en = en;
  assign o_ifid_flush = i_reset | (!frz & (take | (state == FLUSH)));
  assign o_idex_flush = i_reset | take | stl;
  assign o_memwb_bubble = i_reset | frz;
  // next state: a dmem wait freezes everything, including the flush countdown
  always_comb begin
    nxt = frz ? ((state == FLUSH) ? FLUSH : MEMWAIT) :
          take ? ((FLUSH_CYC > 1) ? FLUSH : RUN) :
          (state == FLUSH && fcnt != 4'd1) ? FLUSH : RUN;
    fnxt = frz ? fcnt : take ? 4'(FLUSH_CYC - 1) : (state == FLUSH) ? fcnt - 4'd1 : fcnt;
  end
  // state and flush countdown registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= RUN;
      fcnt <= 4'd0;
    end else begin
      state <= nxt;
      fcnt <= fnxt;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
  // saturating event counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      memwait_cnt <= '0;
    end else begin
      if (stl && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (take && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      if (frz && !(&memwait_cnt)) memwait_cnt <= memwait_cnt + 1'b1;
    end
  end
  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;
  assign o_memwait_cnt = memwait_cnt;
`else
  assign o_stall_cnt = {CNT_W{1'b0}};
  assign o_flush_cnt = {CNT_W{1'b0}};
  assign o_memwait_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with FLUSH_CYC=3
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst, mr, br, req, rdy;
  logic [31:0] ins;
  logic [4:0] rd;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
  logic [6:0] sb[$];
  int checks = 0;
  int errors = 0;
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] RST = 7'b0010101;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] LU  = 7'b0001110;
  localparam logic [6:0] FL  = 7'b1111010;
  localparam logic [31:0] ADD = 32'h00728333;
  localparam logic [31:0] NOP = 32'h00000013;
  hazard_ctrl #(.FLUSH_CYC(3), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_id_instr(ins), .i_ex_rd(rd), .i_ex_memread(mr),
    .i_ex_br_taken(br), .i_mem_req(req), .i_mem_ready(rdy),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush), .o_idex_en(idex_en),
    .o_idex_flush(idex_flush), .o_exmem_en(exmem_en), .o_memwb_bubble(memwb_bubble),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_memwait_cnt(memwait_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic [31:0] i, input logic [4:0] d,
                      input logic m, input logic b, input logic q, input logic y, input logic [6:0] exp);
    @(negedge clk);
    rst = r; ins = i; rd = d; mr = m; br = b; req = q; rdy = y;
    sb.push_back(exp);
    #4;
    chk(tag, {25'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble},
        {25'd0, sb.pop_front()});
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] pe(input int v);
`ifdef HAZARD_PERF_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction
  task automatic cnt(input string tag, input int s, input int f, input int m);
    chk({tag, "_stall"}, stall_cnt, pe(s));
    chk({tag, "_flush"}, flush_cnt, pe(f));
    chk({tag, "_memwait"}, memwait_cnt, pe(m));
  endtask
  initial begin
    rst = 1; ins = NOP; rd = 0; mr = 0; br = 0; req = 0; rdy = 0;
    step("reset0", 1, NOP, 0, 0, 0, 0, 0, RST);
    step("reset1", 1, NOP, 0, 0, 0, 0, 0, RST);
    cnt("after_reset", 0, 0, 0);
    step("lu_rs1", 0, ADD, 5, 1, 0, 0, 0, LU);
    step("lu_release", 0, ADD, 5, 0, 0, 0, 0, DEF);
    step("lu_rs2", 0, ADD, 7, 1, 0, 0, 0, LU);
    step("lui_no_rs1", 0, 32'h000282B7, 5, 1, 0, 0, 0, DEF);
    step("rd_x0", 0, 32'h00000333, 0, 1, 0, 0, 0, DEF);
    step("unknown_op", 0, 32'h0002807F, 5, 1, 0, 0, 0, DEF);
    step("store_rs2", 0, 32'h0050A023, 5, 1, 0, 0, 0, LU);
    step("itype_no_rs2", 0, 32'h00500093, 5, 1, 0, 0, 0, DEF);
    cnt("after_lu", 3, 0, 0);
    step("br_pulse", 0, NOP, 0, 0, 1, 0, 0, BR);
    step("flush_c2", 0, NOP, 0, 0, 0, 0, 0, FL);
    step("flush_c3", 0, NOP, 0, 0, 0, 0, 0, FL);
    step("flush_done", 0, NOP, 0, 0, 0, 0, 0, DEF);
    step("br_lu", 0, ADD, 5, 1, 1, 0, 0, BR);
    step("flush_lu_ign1", 0, ADD, 5, 1, 0, 0, 0, FL);
    step("flush_lu_ign2", 0, ADD, 5, 1, 0, 0, 0, FL);
    step("br_lu_done", 0, ADD, 5, 0, 0, 0, 0, DEF);
    cnt("after_br", 3, 2, 0);
    step("br_fw", 0, NOP, 0, 0, 1, 0, 0, BR);
    step("fw_flush", 0, NOP, 0, 0, 0, 0, 0, FL);
    step("fw_freeze", 0, NOP, 0, 0, 0, 1, 0, FRZ);
    step("fw_hold", 0, NOP, 0, 0, 0, 0, 0, FL);
    step("fw_done", 0, NOP, 0, 0, 0, 0, 0, DEF);
    cnt("after_fw", 3, 3, 1);
    for (int i = 0; i < 4; i++) step("memwait", 0, NOP, 0, 0, 0, 1, 0, FRZ);
    step("mem_ready", 0, NOP, 0, 0, 0, 1, 1, DEF);
    step("mem_idle", 0, NOP, 0, 0, 0, 0, 0, DEF);
    cnt("after_mw", 3, 3, 5);
    step("mw_br1", 0, NOP, 0, 0, 1, 1, 0, FRZ);
    step("mw_br2", 0, NOP, 0, 0, 1, 1, 0, FRZ);
    step("mw_br_rel", 0, NOP, 0, 0, 1, 1, 1, BR);
    step("mw_br_fl1", 0, NOP, 0, 0, 0, 0, 0, FL);
    step("mw_br_fl2", 0, NOP, 0, 0, 0, 0, 0, FL);
    step("mw_br_done", 0, NOP, 0, 0, 0, 0, 0, DEF);
    step("mw_lu", 0, ADD, 5, 1, 0, 1, 0, FRZ);
    step("mw_lu_rel", 0, ADD, 5, 1, 0, 1, 1, LU);
    step("mw_lu_done", 0, ADD, 5, 0, 0, 0, 0, DEF);
    cnt("after_mix", 4, 4, 8);
    step("rst_mw1", 0, NOP, 0, 0, 0, 1, 0, FRZ);
    step("rst_mw2", 1, NOP, 0, 0, 0, 1, 0, RST);
    step("rst_mw_after", 0, NOP, 0, 0, 0, 0, 0, DEF);
    cnt("after_rst_mw", 0, 0, 0);
    step("rst_fl_br", 0, NOP, 0, 0, 1, 0, 0, BR);
    step("rst_fl", 1, NOP, 0, 0, 0, 0, 0, RST);
    step("rst_fl_after", 0, NOP, 0, 0, 0, 0, 0, DEF);
    cnt("after_rst_fl", 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
